// File: rtl/pmem_responder_pkg.sv
// Shared types for the physical-memory responder: bus widths, line payloads and FSM states.
package pmem_responder_pkg;

    localparam int unsigned PMEM_ADDR_W = 16;
    localparam int unsigned LINE_W      = 128;

    typedef logic [PMEM_ADDR_W-1:0] lc3b_pmem_addr;
    typedef logic [LINE_W-1:0]      lc3b_cache_line;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_DONE
    } pmem_state_t;

    // Request fields captured at acceptance; the line index is kept separately
    // because its width depends on the array depth.
    typedef struct packed {
        logic           is_write;
        lc3b_cache_line wdata;
    } pmem_req_t;

endpackage

// File: rtl/pmem_if.sv
// Cache-to-memory line bus: the cache is the master, the responder the slave.
interface pmem_if;
    import pmem_responder_pkg::*;

    logic           pmem_read;
    logic           pmem_write;
    lc3b_pmem_addr  pmem_address;
    lc3b_cache_line pmem_wdata;
    lc3b_cache_line pmem_rdata;
    logic           pmem_resp;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/pmem_responder_array.sv
// Single-port line-wide backing store: synchronous write, registered read.
module pmem_array
    import pmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  lc3b_cache_line        wdata,
    output lc3b_cache_line        rdata
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    lc3b_cache_line mem [DEPTH];

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/pmem_responder.sv
// Target side of the pmem read/write/resp protocol with a fixed response latency.
module pmem_responder
    import pmem_responder_pkg::*;
#(
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned DEPTH_LOG2 = 12
) (
    input  logic   clk,
    input  logic   reset,
    pmem_if.slave  pmem,
    output logic   busy,
    output logic   proto_err
);

    localparam int unsigned CNT_W = $clog2(LATENCY + 1);
    localparam bit          LAT1  = (LATENCY == 1);

    pmem_state_t           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    pmem_req_t             req_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic                  resp_q;

    logic                  req_c;
    logic                  accept_c;
    logic                  drop_err_c;
    logic [DEPTH_LOG2-1:0] addr_idx_c;
    logic                  arr_we_c;
    logic                  arr_re_c;
    logic [DEPTH_LOG2-1:0] arr_idx_c;
    lc3b_cache_line        arr_rdata;
    logic                  unused_addr;

    assign req_c       = pmem.pmem_read | pmem.pmem_write;
    assign addr_idx_c  = pmem.pmem_address[DEPTH_LOG2+3:4];
    assign unused_addr = ^pmem.pmem_address;

    // Next-state and latency countdown.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept_c   = 1'b0;
        drop_err_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_c) begin
                    accept_c = 1'b1;
                    if (LAT1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                drop_err_c = !req_c;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Read is launched a cycle early so the registered array output lands in RESP.
    assign arr_re_c  = (state_q == ST_WAIT && cnt_q == CNT_W'(1) && !req_q.is_write)
                     || (LAT1 && accept_c && !pmem.pmem_write);
    assign arr_we_c  = (state_q == ST_RESP) && req_q.is_write;
    assign arr_idx_c = (state_q == ST_IDLE) ? addr_idx_c : idx_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            idx_q     <= '0;
            resp_q    <= 1'b0;
            busy      <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= (state_d == ST_RESP);
            busy    <= (state_d != ST_IDLE);
            if (accept_c) begin
                req_q.is_write <= pmem.pmem_write;
                req_q.wdata    <= pmem.pmem_wdata;
                idx_q          <= addr_idx_c;
            end
            if ((accept_c && pmem.pmem_read && pmem.pmem_write) || drop_err_c) begin
                proto_err <= 1'b1;
            end
        end
    end

    pmem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (arr_we_c),
        .re    (arr_re_c),
        .idx   (arr_idx_c),
        .wdata (req_q.wdata),
        .rdata (arr_rdata)
    );

    assign pmem.pmem_resp  = resp_q;
    assign pmem.pmem_rdata = arr_rdata;

endmodule

// File: tb/tb_pmem_responder.sv
// Bench for pmem_responder: transaction-level model for the LATENCY=4 instance,
// hand-computed cycle checks for a LATENCY=1 instance.
module tb_pmem_responder;

    localparam int LAT = 4;
    localparam logic [127:0] D_T1  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] D_OLD = 128'h11111111222222223333333344444444;
    localparam logic [127:0] D_NEW = 128'hAAAAAAAABBBBBBBBCCCCCCCCDDDDDDDD;
    localparam logic [127:0] D_RW  = 128'hDEADBEEFCAFEF00D0BADC0DE12345678;
    localparam logic [127:0] D_L1  = 128'h5A5A5A5AA5A5A5A5FEDCBA9876543210;

    logic clk = 1'b0;
    logic reset;
    logic busy0, err0, busy1, err1;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    pmem_if p0 ();
    pmem_if p1 ();

    pmem_responder #(.LATENCY(4), .DEPTH_LOG2(12)) dut0 (
        .clk(clk), .reset(reset), .pmem(p0), .busy(busy0), .proto_err(err0)
    );
    pmem_responder #(.LATENCY(1), .DEPTH_LOG2(12)) dut1 (
        .clk(clk), .reset(reset), .pmem(p1), .busy(busy1), .proto_err(err1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, 128'(act), 128'(exp));
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        chk(name, 128'(act), 128'(exp));
    endtask

    // Model: a request seen at the end of cycle c while free is accepted; resp in
    // c+LAT, busy through c+LAT+1, write lands at the end of c+LAT.
    logic [127:0] mem_m [int];
    bit           has_acc = 0, in_flight = 0, m_wr = 0;
    int           acc_c = 0, m_idx = 0;
    logic [127:0] m_wdata = '0;
    logic         exp_resp = 0, exp_busy = 0, exp_err = 0;
    logic [127:0] exp_rdata = '0;
    bit           rdata_known = 1;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            has_acc = 0; in_flight = 0;
            exp_resp = 0; exp_busy = 0; exp_err = 0;
            exp_rdata = '0; rdata_known = 1;
        end else begin
            int c;
            c = cyc;
            if (in_flight && c > acc_c && c < acc_c + LAT && !(p0.pmem_read || p0.pmem_write))
                exp_err = 1;
            if (in_flight && c == acc_c + LAT) begin
                in_flight = 0;
                if (m_wr) mem_m[m_idx] = m_wdata;
            end else if (!in_flight && (!has_acc || c >= acc_c + LAT + 2)
                         && (p0.pmem_read || p0.pmem_write)) begin
                has_acc = 1; in_flight = 1; acc_c = c;
                m_wr = p0.pmem_write;
                m_idx = (int'(p0.pmem_address) / 16) % 4096;
                m_wdata = p0.pmem_wdata;
                if (p0.pmem_read && p0.pmem_write) exp_err = 1;
            end
            exp_resp = in_flight && (c + 1 == acc_c + LAT);
            exp_busy = has_acc && (c + 1 <= acc_c + LAT + 1);
            if (exp_resp && !m_wr) begin
                if (mem_m.exists(m_idx)) begin
                    exp_rdata = mem_m[m_idx]; rdata_known = 1;
                end else begin
                    rdata_known = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk1("m_resp", p0.pmem_resp, exp_resp);
        chk1("m_busy", busy0, exp_busy);
        chk1("m_proto_err", err0, exp_err);
        if (rdata_known) chk("m_rdata", p0.pmem_rdata, exp_rdata);
    end

    task automatic wait_resp(output int rc, output logic [127:0] rd);
        rc = -1; rd = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (p0.pmem_resp) begin rc = cyc; rd = p0.pmem_rdata; break; end
        end
        if (rc < 0) begin
            n_total++;
            $display("FAIL resp_timeout: no pmem_resp in 40 cycles, expected one");
        end
    endtask

    task automatic do_txn(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [127:0] d, output int ta, output int tr,
                          output logic [127:0] rdat);
        @(posedge clk); #1;
        p0.pmem_read = rd; p0.pmem_write = wr; p0.pmem_address = a; p0.pmem_wdata = d;
        ta = cyc;
        wait_resp(tr, rdat);
        @(posedge clk); #1;
        p0.pmem_read = 0; p0.pmem_write = 0;
    endtask

    // LATENCY=1: resp in T+1, busy in T+1..T+2, idle from T+3.
    task automatic l1_txn(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [127:0] d, input logic [127:0] exp_rd);
        @(posedge clk); #1;
        p1.pmem_read = rd; p1.pmem_write = wr; p1.pmem_address = a; p1.pmem_wdata = d;
        @(negedge clk);
        chk1("l1_resp_T0", p1.pmem_resp, 1'b0);
        chk1("l1_busy_T0", busy1, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            if (i == 2) begin p1.pmem_read = 0; p1.pmem_write = 0; end
            @(negedge clk);
            chk1("l1_resp", p1.pmem_resp, i == 1);
            chk1("l1_busy", busy1, i <= 2);
            if (i == 1 && rd) chk("l1_rdata", p1.pmem_rdata, exp_rd);
        end
    endtask

    initial begin
        int ta, tr, n;
        logic [127:0] rdat;
        reset = 1;
        p0.pmem_read = 0; p0.pmem_write = 0; p0.pmem_address = '0; p0.pmem_wdata = '0;
        p1.pmem_read = 0; p1.pmem_write = 0; p1.pmem_address = '0; p1.pmem_wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk1("rst_resp", p0.pmem_resp, 1'b0);
        chk1("rst_busy", busy0, 1'b0);
        chk1("rst_err", err0, 1'b0);
        chk("rst_rdata", p0.pmem_rdata, 128'h0);
        chk1("rst_l1_busy", busy1, 1'b0);
        chk("rst_l1_rdata", p1.pmem_rdata, 128'h0);

        // Write then read the same line via a different low nibble.
        do_txn(0, 1, 16'h1230, D_T1, ta, tr, rdat);
        chk_int("t1_wr_latency", tr - ta, 4);
        do_txn(1, 0, 16'h1234, '0, ta, tr, rdat);
        chk_int("t1_rd_latency", tr - ta, 4);
        chk("t1_rdata", rdat, D_T1);

        // Read held through resp and DONE: one pulse, then re-accepted at T+6.
        @(posedge clk); #1;
        p0.pmem_read = 1; p0.pmem_address = 16'h1230; ta = cyc;
        n = 0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); if (p0.pmem_resp) n++; end
        chk_int("t3_one_pulse", n, 1);
        wait_resp(tr, rdat);
        chk_int("t3_rerequest_resp", tr - ta, 10);
        chk("t3_rdata", rdat, D_T1);
        @(posedge clk); #1; p0.pmem_read = 0;
        chk1("t3_no_err", err0, 1'b0);

        // Read dropped after one cycle still completes, flags error.
        @(posedge clk); #1;
        p0.pmem_read = 1; p0.pmem_address = 16'h1238; ta = cyc;
        @(posedge clk); #1; p0.pmem_read = 0; p0.pmem_address = 16'h0040;
        wait_resp(tr, rdat);
        chk_int("t6_latency", tr - ta, 4);
        chk("t6_rdata", rdat, D_T1);
        @(posedge clk); #1;
        chk1("t6_err", err0, 1'b1);

        // Reset during the WAIT of a write: no commit, no resp.
        do_txn(0, 1, 16'h0080, D_OLD, ta, tr, rdat);
        @(posedge clk); #1;
        p0.pmem_write = 1; p0.pmem_address = 16'h0080; p0.pmem_wdata = D_NEW;
        @(posedge clk); #1;
        @(posedge clk); #1; reset = 1;
        n = 0;
        @(negedge clk); if (p0.pmem_resp) n++;
        @(posedge clk); #1; reset = 0; p0.pmem_write = 0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); if (p0.pmem_resp) n++; end
        chk_int("t5_no_resp", n, 0);
        chk1("t5_err_cleared", err0, 1'b0);
        do_txn(1, 0, 16'h0080, '0, ta, tr, rdat);
        chk("t5_old_data", rdat, D_OLD);

        // Read and write together: write wins, sticky error.
        do_txn(1, 1, 16'h0040, D_RW, ta, tr, rdat);
        chk1("t4_err", err0, 1'b1);
        do_txn(1, 0, 16'h0040, '0, ta, tr, rdat);
        chk("t4_written", rdat, D_RW);
        chk1("t4_err_sticky", err0, 1'b1);

        // LATENCY=1 instance.
        l1_txn(0, 1, 16'h0100, D_L1, '0);
        l1_txn(1, 0, 16'h0108, '0, D_L1);
        chk1("l1_no_err", err1, 1'b0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
